// File: rtl/crypto_xor_stream.sv
// -----------------------------------------------------------------------------
// crypto_xor_stream
//   AXI4-Stream payload cipher stage. Every byte past the first HDR_BYTES of a
//   packet is XORed with a 32-bit key. Key byte k covers payload offsets that
//   are congruent to k modulo 4, and key byte 0 is key[7:0]. The key and the
//   enable are captured once, when the first beat of each packet is read.
//   Input beats are buffered in a small fall-through FIFO. The master side is
//   fully registered and moves one beat per cycle.
//
// Optional build macro: CRYPTO_STATS_EN. When it is defined, the packet and
//   encrypted-byte counters are built. When it is not defined, both counter
//   ports are tied to 0.
//
// Ports
//   axis_aclk, axis_resetn   clock, asynchronous active-low reset
//   s_axis_*                 slave stream (tdata/tkeep/tuser/tvalid/tlast in,
//                            tready out)
//   m_axis_*                 registered master stream (tready in)
//   key, crypto_en           cipher key and per-packet enable, sampled at SOP
//   pkt_count                completed packets (CRYPTO_STATS_EN)
//   enc_byte_count           bytes actually XORed (CRYPTO_STATS_EN)
// -----------------------------------------------------------------------------
module crypto_xor_stream #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int FIFO_DEPTH_BITS      = 2,
   parameter int HDR_BYTES            = 42
) (
   input  logic                              axis_aclk,
   input  logic                              axis_resetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   input  logic [31:0]                       key,
   input  logic                              crypto_en,
   output logic [31:0]                       pkt_count,
   output logic [31:0]                       enc_byte_count
);
   localparam int W     = C_M_AXIS_DATA_WIDTH;
   localparam int U     = C_M_AXIS_TUSER_WIDTH;
   localparam int KB    = W / 8;
   localparam int FW    = W + U + KB + 1;
   localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
   localparam int MAXB  = (HDR_BYTES + KB - 1) / KB;
   localparam int BIW   = (MAXB > 0) ? $clog2(MAXB + 1) : 1;
   localparam int CW    = $clog2(KB + 1);

   localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE  = 1;
   localparam logic [FIFO_DEPTH_BITS:0]   CNT_NF   = (FIFO_DEPTH_BITS + 1)'(DEPTH - 1);
   localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE  = 1;
   localparam logic [BIW-1:0]             BEAT_ONE = 1;
   localparam logic [BIW-1:0]             BEAT_MAX = BIW'(MAXB);

   typedef enum logic {ST_SOP = 1'b0, ST_MID = 1'b1} state_t;

   // ---------------- input fall-through FIFO ----------------
   logic [FW-1:0]              mem_q [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_DEPTH_BITS:0]   cnt_q, cnt_d;
   logic                       fifo_wr_en, fifo_rd_en, fifo_empty, nearly_full;
   logic [FW-1:0]              fifo_dout;
   logic                       m_tvalid_q;

   assign fifo_empty  = (cnt_q == '0);
   assign nearly_full = (cnt_q >= CNT_NF);
   // Gated by reset so the slave side never looks ready while in reset.
   assign s_axis_tready = axis_resetn & ~nearly_full;
   assign fifo_wr_en    = s_axis_tvalid & s_axis_tready;
   assign fifo_rd_en    = ~fifo_empty & (~m_tvalid_q | m_axis_tready);
   assign fifo_dout     = mem_q[rd_ptr_q];

   always_comb begin
      cnt_d = cnt_q;
      case ({fifo_wr_en, fifo_rd_en})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   // The storage has no reset. Only the pointers and the count are cleared.
   always_ff @(posedge axis_aclk) begin
      if (fifo_wr_en) mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tkeep, s_axis_tuser, s_axis_tdata};
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (fifo_wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (fifo_rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         cnt_q <= cnt_d;
      end
   end

   // ---------------- cipher datapath ----------------
   logic [W-1:0]  f_data;
   logic [U-1:0]  f_user;
   logic [KB-1:0] f_keep;
   logic          f_last;
   assign {f_last, f_keep, f_user, f_data} = fifo_dout;

   state_t         state_q;
   logic [BIW-1:0] beat_idx_q;
   logic [31:0]    key_q;
   logic           en_q;

   // A beat read in SOP is ciphered with the live key and enable, which are
   // captured on that same read.
   logic [31:0]   key_use;
   logic          en_use;
   logic [KB-1:0] xor_mask;
   logic [W-1:0]  xor_data;
   assign key_use = (state_q == ST_SOP) ? key : key_q;
   assign en_use  = (state_q == ST_SOP) ? crypto_en : en_q;

   // beat_idx saturates at the first beat that lies fully past the header.
   // From that beat on, every offset compares as payload.
   genvar gi;
   generate
      for (gi = 0; gi < KB; gi++) begin : g_byte
         logic [31:0] offset;
         assign offset = 32'(beat_idx_q) * 32'(KB) + 32'(gi);
         assign xor_mask[gi] = en_use & f_keep[gi] & (offset >= 32'(HDR_BYTES));
         assign xor_data[gi*8 +: 8] = f_data[gi*8 +: 8] ^ (key_use[(gi%4)*8 +: 8] & {8{xor_mask[gi]}});
      end
   endgenerate

   // ---------------- FSM + registered master output ----------------
   logic [W-1:0]  m_tdata_q;
   logic [KB-1:0] m_tkeep_q;
   logic [U-1:0]  m_tuser_q;
   logic          m_tlast_q;

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state_q    <= ST_SOP;
         beat_idx_q <= '0;
         key_q      <= '0;
         en_q       <= 1'b0;
         m_tvalid_q <= 1'b0;
         m_tlast_q  <= 1'b0;
         m_tdata_q  <= '0;
         m_tkeep_q  <= '0;
         m_tuser_q  <= '0;
      end else if (fifo_rd_en) begin
         m_tdata_q  <= xor_data;
         m_tkeep_q  <= f_keep;
         m_tuser_q  <= f_user;
         m_tlast_q  <= f_last;
         m_tvalid_q <= 1'b1;
         if (state_q == ST_SOP) begin
            key_q <= key;
            en_q  <= crypto_en;
         end
         state_q <= f_last ? ST_SOP : ST_MID;
         if (f_last)
            beat_idx_q <= '0;
         else if (beat_idx_q != BEAT_MAX)
            beat_idx_q <= beat_idx_q + BEAT_ONE;
      end else if (m_axis_tready) begin
         m_tvalid_q <= 1'b0;
      end
   end

   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tkeep  = m_tkeep_q;
   assign m_axis_tuser  = m_tuser_q;
   assign m_axis_tlast  = m_tlast_q;
   assign m_axis_tvalid = m_tvalid_q;

   // ---------------- statistics ----------------
`ifdef CRYPTO_STATS_EN
   logic [CW-1:0] xor_cnt;
   logic [CW-1:0] m_enc_q;   // XORed-byte count of the beat in the output register
   logic [31:0]   pkt_count_q, enc_byte_count_q;

   always_comb begin
      xor_cnt = '0;
      for (int i = 0; i < KB; i++) xor_cnt = xor_cnt + CW'(xor_mask[i]);
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         m_enc_q          <= '0;
         pkt_count_q      <= '0;
         enc_byte_count_q <= '0;
      end else begin
         if (fifo_rd_en) m_enc_q <= xor_cnt;
         if (m_tvalid_q && m_axis_tready) begin
            enc_byte_count_q <= enc_byte_count_q + 32'(m_enc_q);
            if (m_tlast_q) pkt_count_q <= pkt_count_q + 32'd1;
         end
      end
   end

   assign pkt_count      = pkt_count_q;
   assign enc_byte_count = enc_byte_count_q;
`else
   assign pkt_count      = '0;
   assign enc_byte_count = '0;
`endif

endmodule

// File: tb/tb_crypto_xor_stream.sv
`timescale 1ns/1ps
module tb_crypto_xor_stream;
   localparam int W   = 256;
   localparam int U   = 128;
   localparam int KB  = W / 8;
   localparam int HDR = 42;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  s_axis_tdata = '0;
   logic [KB-1:0] s_axis_tkeep = '0;
   logic [U-1:0]  s_axis_tuser = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tlast = 1'b0;
   logic          s_axis_tready;
   logic [W-1:0]  m_axis_tdata;
   logic [KB-1:0] m_axis_tkeep;
   logic [U-1:0]  m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready = 1'b1;
   logic [31:0]   key = '0;
   logic          crypto_en = 1'b0;
   logic [31:0]   pkt_count;
   logic [31:0]   enc_byte_count;

   always #5 clk = ~clk;

   crypto_xor_stream #(
      .C_M_AXIS_DATA_WIDTH (W),
      .C_S_AXIS_DATA_WIDTH (W),
      .C_M_AXIS_TUSER_WIDTH(U),
      .C_S_AXIS_TUSER_WIDTH(U),
      .FIFO_DEPTH_BITS     (2),
      .HDR_BYTES           (HDR)
   ) dut (
      .axis_aclk     (clk),
      .axis_resetn   (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .key           (key),
      .crypto_en     (crypto_en),
      .pkt_count     (pkt_count),
      .enc_byte_count(enc_byte_count)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [W-1:0]  data;
      logic [KB-1:0] keep;
      logic [U-1:0]  user;
      logic          last;
      int            nenc;
      int            edge_n;
      bit            lat;
   } beat_t;

   beat_t       sb[$];
   beat_t       pe, ne;
   int          cyc = 0;
   bit          m_sop = 1'b1;
   logic [31:0] m_key = '0;
   bit          m_en = 1'b0;
   int          m_beat = 0;
   int          acc_cnt = 0;
   bit          lat_mode = 1'b0;
   logic [31:0] exp_pkt = '0;
   logic [31:0] exp_enc = '0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Outputs and accepts are sampled on the falling edge. A handshake seen
   // here completes on the following rising edge, which is edge cyc+1.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         sb.delete();
         m_sop   = 1'b1;
         m_beat  = 0;
         exp_pkt = '0;
         exp_enc = '0;
      end else begin
         if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
               check_val("spurious_beat", 256'd1, 256'd0);
            end else begin
               pe = sb.pop_front();
               check_val("data", m_axis_tdata, pe.data);
               check_val("keep_user_last", {m_axis_tkeep, m_axis_tuser, m_axis_tlast},
                         {pe.keep, pe.user, pe.last});
               if (pe.lat) check_val("latency", 256'(cyc + 1 - pe.edge_n), 256'd2);
               exp_enc = exp_enc + 32'(pe.nenc);
               if (pe.last) exp_pkt = exp_pkt + 32'd1;
               $display("out beat last=%0d enc_bytes=%0d", pe.last, pe.nenc);
            end
         end
         if (s_axis_tvalid && s_axis_tready) begin
            if (m_sop) begin
               m_key  = key;
               m_en   = crypto_en;
               m_beat = 0;
            end
            ne.data = s_axis_tdata;
            ne.nenc = 0;
            for (int i = 0; i < KB; i++) begin
               if (m_en && s_axis_tkeep[i] && (m_beat * KB + i >= HDR)) begin
                  ne.data[i*8 +: 8] = s_axis_tdata[i*8 +: 8] ^ m_key[(i%4)*8 +: 8];
                  ne.nenc++;
               end
            end
            ne.keep   = s_axis_tkeep;
            ne.user   = s_axis_tuser;
            ne.last   = s_axis_tlast;
            ne.edge_n = cyc + 1;
            ne.lat    = lat_mode;
            sb.push_back(ne);
            m_beat++;
            m_sop = s_axis_tlast;
            acc_cnt++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [W-1:0] rand_data();
      logic [W-1:0] d;
      for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic send_beat(input logic [W-1:0] d, input logic [KB-1:0] k, input logic last);
      int t;
      t = 0;
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      @(negedge clk);
      while (!s_axis_tready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!s_axis_tready) check_val("accept_timeout", 256'd1, 256'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input int n, input bit zeros, input logic [KB-1:0] last_keep);
      for (int b = 0; b < n; b++)
         send_beat(zeros ? '0 : rand_data(), (b == n - 1) ? last_keep : '1, b == n - 1);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      #1;
      check_val("drain_empty", 256'(sb.size()), 256'd0);
   endtask

   task automatic check_stats(input string tag);
`ifdef CRYPTO_STATS_EN
      check_val({tag, "_pkt_count"}, 256'(pkt_count), 256'(exp_pkt));
      check_val({tag, "_enc_bytes"}, 256'(enc_byte_count), 256'(exp_enc));
`else
      check_val({tag, "_pkt_count"}, 256'(pkt_count), 256'd0);
      check_val({tag, "_enc_bytes"}, 256'(enc_byte_count), 256'd0);
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- main sequence ----------------
   initial begin
      int acc0;
      logic stall_acc;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_tvalid", 256'(m_axis_tvalid), 256'd0);
      check_val("rst_tlast", 256'(m_axis_tlast), 256'd0);
      check_val("rst_tdata", m_axis_tdata, 256'd0);
      check_val("rst_keep_user", {m_axis_tkeep, m_axis_tuser}, 256'd0);
      check_val("rst_s_tready", 256'(s_axis_tready), 256'd0);
      check_stats("rst");
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_val("s_tready_after_rst", 256'(s_axis_tready), 256'd1);

      // A: 64-byte packet of zeros, key A5, cipher on
      lat_mode  = 1'b1;
      key       = 32'hA5A5A5A5;
      crypto_en = 1'b1;
      send_pkt(2, 1'b1, '1);
      drain();
      check_stats("A");

      // B: bypass, random payload
      crypto_en = 1'b0;
      send_pkt(2, 1'b0, '1);
      send_pkt(3, 1'b0, '1);
      drain();
      check_stats("B");

      // C: key changes mid-packet; the next packet picks up the new key
      crypto_en = 1'b1;
      key = 32'h01020304;
      send_beat(rand_data(), '1, 1'b0);
      send_beat(rand_data(), '1, 1'b0);
      key = 32'hFFFFFFFF;
      send_beat(rand_data(), '1, 1'b0);
      send_beat(rand_data(), '1, 1'b1);
      send_pkt(2, 1'b0, '1);
      drain();
      check_stats("C");

      // D: output stalled for 20 cycles during back-to-back 1-beat packets
      lat_mode = 1'b0;
      key = 32'h5A3C96E1;
      m_axis_tready = 1'b0;
      acc0 = acc_cnt;
      s_axis_tdata  = rand_data();
      s_axis_tkeep  = '1;
      s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
      s_axis_tlast  = 1'b1;
      s_axis_tvalid = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         stall_acc = s_axis_tready;
         @(posedge clk);
         #1;
         if (stall_acc) begin
            s_axis_tdata = rand_data();
            s_axis_tuser = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      check_val("stall_accepts", 256'(acc_cnt - acc0), 256'd4);
      check_val("stall_s_tready", 256'(s_axis_tready), 256'd0);
      check_val("stall_m_tvalid", 256'(m_axis_tvalid), 256'd1);
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      drain();
      check_stats("D");

      // E: last beat of a 3-beat packet keeps only bytes 0..3 (offsets 64..67)
      lat_mode = 1'b1;
      key = 32'hC3D2E1F0;
      send_pkt(3, 1'b0, 32'h0000000F);
      drain();
      check_stats("E");

      // F: reset in the middle of a packet with beats still buffered
      lat_mode = 1'b0;
      m_axis_tready = 1'b0;
      send_beat(rand_data(), '1, 1'b0);
      send_beat(rand_data(), '1, 1'b0);
      send_beat(rand_data(), '1, 1'b0);
      s_axis_tvalid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_val("midrst_tvalid", 256'(m_axis_tvalid), 256'd0);
      check_val("midrst_s_tready", 256'(s_axis_tready), 256'd0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      m_axis_tready = 1'b1;
      @(posedge clk);
      #1;
      check_val("postrst_tvalid", 256'(m_axis_tvalid), 256'd0);
      check_stats("F0");
      lat_mode = 1'b1;
      key = 32'h13579BDF;
      send_pkt(1, 1'b0, '1);
      send_pkt(2, 1'b0, '1);
      drain();
      check_stats("F1");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/crypto_xor_stream.md
# crypto_xor_stream

Parametrised AXI4-Stream payload cipher stage for the crypto switch datapath, placed between the input arbiter and the output port lookup. Each packet's bytes beyond a configurable header offset are XORed with a 32-bit key, and header bytes pass through unchanged. Key and enable are sampled once per packet at start-of-packet. The block buffers input in a small fall-through FIFO of parametrised depth and drives a registered master interface at one beat per cycle.

## Interface
- C_M_AXIS_DATA_WIDTH, 256: master tdata width; multiple of 32, range 64..512.
- C_S_AXIS_DATA_WIDTH, 256: slave tdata width; must equal C_M_AXIS_DATA_WIDTH.
- C_M_AXIS_TUSER_WIDTH, 128: master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128: slave tuser width; must equal master.
- FIFO_DEPTH_BITS, 2: log2 of input FIFO depth, range 2..6.
- HDR_BYTES, 42: leading bytes per packet left unencrypted (Eth+IPv4+UDP), range 0..1023.
- axis_aclk  in  1  single clock for all logic.
- axis_resetn  in  1  asynchronous active-low reset.
- s_axis_tdata / tkeep / tuser / tvalid / tlast  in  W / W/8 / U / 1 / 1  slave stream.
- s_axis_tready  out  1  high when FIFO not nearly full.
- m_axis_tdata / tkeep / tuser / tvalid / tlast  out  W / W/8 / U / 1 / 1  master stream, all registered.
- m_axis_tready  in  1  downstream ready.
- key  in  32  cipher key; byte k applies to payload offset ≡ k mod 4.
- crypto_en  in  1  1 = cipher packet, 0 = bypass; sampled at SOP.
- pkt_count  out  32  completed packets (CRYPTO_STATS_EN only).
- enc_byte_count  out  32  bytes actually XORed (CRYPTO_STATS_EN only).

## Operation
- Input FIFO is a fall-through FIFO with width W+U+W/8+1 and depth 2^FIFO_DEPTH_BITS. Write on s_axis_tvalid & s_axis_tready. s_axis_tready = !nearly_full.
- FSM has two states, SOP and MID. Reset state is SOP.
  - In SOP, reading a beat latches key into key_q and crypto_en into en_q, and applies the new values to that beat.
  - Go to MID if the beat's tlast=0. Stay in SOP if tlast=1 (single-beat packet).
  - In MID, reading a beat with tlast=1 returns to SOP.
- Beat counter beat_idx counts beats within the packet. It resets to 0 after a tlast beat read. It saturates at ceil(HDR_BYTES/(W/8)), so its width is log2 of that value + 1.
- Byte i of a beat has global offset beat_idx*(W/8)+i. It is XORed with key_q byte (i mod 4) only when all three hold: en_q=1, offset ≥ HDR_BYTES, tkeep[i]=1. All other bytes pass through unchanged.
- tkeep, tuser and tlast pass through unmodified.
- fifo_rd_en = !fifo_empty & (!m_axis_tvalid | m_axis_tready). The output register loads whenever fifo_rd_en is high.
- m_axis_tvalid: set on load, cleared when m_axis_tready is high and nothing loads.
- Key or crypto_en changes mid-packet have no effect until the next SOP.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0, state=SOP, beat_idx=0, key_q=0, en_q=0, counters=0.
- s_axis_tready is low while reset is asserted.
- Latency: a beat accepted at cycle N appears on m_axis at N+2 when m_axis_tready is held high.
- Throughput is 1 beat/cycle with no bubbles between packets.
- Backpressure:
  - The output holds stable while tvalid=1 & tready=0.
  - s_axis_tready drops once FIFO occupancy reaches depth−1.
- Simultaneous FIFO write and read at nearly-full is legal and occupancy is unchanged.
- Reset asserted mid-packet drops all buffered beats and clears the FSM to SOP. The next accepted beat is treated as SOP.

## Configuration
- CRYPTO_STATS_EN defined:
  - pkt_count increments on every m_axis tlast handshake.
  - enc_byte_count adds the number of XORed bytes of each output handshake.
  - Both wrap modulo 2^32 and reset to 0.
- CRYPTO_STATS_EN undefined: both ports are driven constant 0 and no counter logic is built.

## Test plan
- W=256, HDR_BYTES=42, key=0xA5A5A5A5, crypto_en=1, 64-byte packet of 0x00 -> beat0 bytes 0..31 are 0x00; beat1 bytes 32..41 are 0x00 and bytes 42..63 are 0xA5; tlast on beat1 at N+3.
- crypto_en=0, same packet -> output equals input bit-for-bit; enc_byte_count unchanged.
- Key changed from 0x01020304 to 0xFFFFFFFF at beat 2 of a 4-beat packet -> all payload XORed with 0x01020304; the next packet uses 0xFFFFFFFF.
- m_axis_tready=0 for 20 cycles during back-to-back 1-beat packets -> s_axis_tready falls after 4 accepts (depth 4, nearly-full at 3 plus 1 in the output register); no beat lost or duplicated; order preserved.
- Last beat tkeep=0x0000000F with payload offset ≥42 -> only bytes 0..3 XORed; enc_byte_count += 4.
- axis_resetn pulsed low mid-packet -> m_axis_tvalid=0 next edge; a following 1-beat packet is ciphered from offset 0 using the freshly sampled key; pkt_count=0 then 1.
